// File: rtl/reg_dest_pipe.sv
// Write-destination selector feeding a DEPTH-stage tracking pipe.
// Each stage reports source matches, which drive hazard and forwarding outputs.
module reg_dest_stage #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              clr,
  input  logic [ADDR_W-1:0] d_dest,
  input  logic              d_vld,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] q_dest,
  output logic              q_vld,
  output logic              hit_a,
  output logic              hit_b
);
  logic [ADDR_W-1:0] dest_q;
  logic              vld_q;

  // A flush clears only the valid bit. The destination keeps its old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_q <= '0;
      vld_q  <= 1'b0;
    end else if (clr) begin
      vld_q  <= 1'b0;
    end else if (!hold) begin
      dest_q <= d_dest;
      vld_q  <= d_vld;
    end
  end

  assign q_dest = dest_q;
  assign q_vld  = vld_q;
  assign hit_a  = vld_q && (dest_q == src_a) && (src_a != '0);
  assign hit_b  = vld_q && (dest_q == src_b) && (src_b != '0);
endmodule

module reg_dest_pipe #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 3,
  parameter int RA_IDX = 31,
  parameter int SP_IDX = 29
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic                    RegWrite,
  input  logic [SEL_W-1:0]        RegDest,
  input  logic [ADDR_W-1:0]       RT,
  input  logic [ADDR_W-1:0]       RD,
  input  logic [ADDR_W-1:0]       RS,
  input  logic [ADDR_W-1:0]       src_a,
  input  logic [ADDR_W-1:0]       src_b,
  output logic [ADDR_W-1:0]       sel_dest,
  output logic [DEPTH*ADDR_W-1:0] stage_dest,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [ADDR_W-1:0]       wb_dest,
  output logic                    wb_valid,
  output logic                    hazard_a,
  output logic                    hazard_b,
  output logic [2:0]              fwd_a,
  output logic [2:0]              fwd_b,
  output logic                    err_sel
);
  logic                         legal;
  logic                         cand_valid;
  logic [DEPTH:0][ADDR_W-1:0]   dest_chain;
  logic [DEPTH:0]               vld_pipe;
  logic [DEPTH-1:0]             hit_a, hit_b;
  logic                         err_sel_q, err_sel_d;

  always_comb begin
    sel_dest = '0;
    legal    = 1'b1;
    case (RegDest)
      SEL_W'(0): sel_dest = RT;
      SEL_W'(1): sel_dest = RD;
      SEL_W'(2): sel_dest = ADDR_W'(RA_IDX);
      SEL_W'(3): sel_dest = ADDR_W'(SP_IDX);
      SEL_W'(4): sel_dest = RS;
      default:   legal    = 1'b0;
    endcase
  end

  // Writes to register 0 are never tracked.
  assign cand_valid    = in_valid && RegWrite && legal && (sel_dest != '0);
  assign dest_chain[0] = sel_dest;
  assign vld_pipe[0]   = cand_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    reg_dest_stage #(.ADDR_W(ADDR_W)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .hold   (stall),
      .clr    (flush),
      .d_dest (dest_chain[i]),
      .d_vld  (vld_pipe[i]),
      .src_a  (src_a),
      .src_b  (src_b),
      .q_dest (dest_chain[i+1]),
      .q_vld  (vld_pipe[i+1]),
      .hit_a  (hit_a[i]),
      .hit_b  (hit_b[i])
    );
  end

  assign stage_dest  = dest_chain[DEPTH:1];
  assign stage_valid = vld_pipe[DEPTH:1];
  assign wb_dest     = dest_chain[DEPTH];
  assign wb_valid    = vld_pipe[DEPTH];
  assign hazard_a    = |hit_a;
  assign hazard_b    = |hit_b;

  // Scan from oldest to youngest so that the youngest match is written last.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_a[i]) fwd_a = 3'(i + 1);
      if (hit_b[i]) fwd_b = 3'(i + 1);
    end
  end

  assign err_sel_d = err_sel_q || (in_valid && !stall && !flush && !legal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_sel_q <= 1'b0;
    else        err_sel_q <= err_sel_d;
  end

  assign err_sel = err_sel_q;
endmodule

// File: tb/tb_reg_dest_pipe.sv
// Directed bench for reg_dest_pipe at its default parameters (DEPTH=3).
module tb_reg_dest_pipe;
  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, RegWrite;
  logic [2:0]  RegDest;
  logic [4:0]  RT, RD, RS, src_a, src_b;
  logic [4:0]  sel_dest, wb_dest;
  logic [14:0] stage_dest;
  logic [2:0]  stage_valid, fwd_a, fwd_b;
  logic        wb_valid, hazard_a, hazard_b, err_sel;

  int n_cmp = 0;
  int n_err = 0;

  reg_dest_pipe dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .RegWrite(RegWrite), .RegDest(RegDest),
    .RT(RT), .RD(RD), .RS(RS), .src_a(src_a), .src_b(src_b),
    .sel_dest(sel_dest), .stage_dest(stage_dest), .stage_valid(stage_valid),
    .wb_dest(wb_dest), .wb_valid(wb_valid), .hazard_a(hazard_a),
    .hazard_b(hazard_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] code, input logic [4:0] rd);
    in_valid = 1'b1; RegWrite = 1'b1; RegDest = code; RD = rd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  logic [4:0] exp_wb [5];

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; RegWrite = 1'b0;
    RegDest = 3'b000; RT = 5'd5; RD = 5'd9; RS = 5'd17; src_a = 5'd0; src_b = 5'd0;
    exp_wb = '{5'd5, 5'd9, 5'd31, 5'd29, 5'd17};
    #12;
    chk("rst_stage_valid", stage_valid, 3'b000);
    chk("rst_stage_dest", stage_dest, 15'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_err_sel", err_sel, 1'b0);
    reset = 1'b1;
    step();

    // Decode sweep: codes 000..100 on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        in_valid = 1'b1; RegWrite = 1'b1; RegDest = 3'(i);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i == 1) chk("sweep_not_yet_wb", wb_valid, 1'b0);
      if (i >= 2 && i <= 6) begin
        chk($sformatf("sweep_wb_dest%0d", i - 2), wb_dest, exp_wb[i - 2]);
        chk($sformatf("sweep_wb_valid%0d", i - 2), wb_valid, 1'b1);
      end
      if (i == 7) chk("sweep_wb_empty", wb_valid, 1'b0);
    end
    chk("err_clear_after_legal", err_sel, 1'b0);

    // Illegal code while idle must not set err_sel
    RegDest = 3'b111; in_valid = 1'b0;
    #1 chk("illegal_sel_dest", sel_dest, 5'd0);
    step();
    chk("illegal_idle_no_err", err_sel, 1'b0);
    issue(3'b110, 5'd9);
    chk("illegal_err_set", err_sel, 1'b1);
    chk("illegal_no_entry", stage_valid[0], 1'b0);
    RegWrite = 1'b0; in_valid = 1'b1; RegDest = 3'b001; RD = 5'd9;
    step();
    chk("nowrite_no_entry", stage_valid[0], 1'b0);
    issue(3'b001, 5'd0);
    chk("r0_no_entry", stage_valid[0], 1'b0);
    RegDest = 3'b010;
    #1 chk("comb_sel_ra", sel_dest, 5'd31);
    drain();

    // Hazard and forwarding
    issue(3'b001, 5'd9);
    issue(3'b001, 5'd12);
    src_a = 5'd9; src_b = 5'd12;
    #1;
    chk("haz_a", hazard_a, 1'b1);
    chk("haz_b", hazard_b, 1'b1);
    chk("fwd_a_old", fwd_a, 3'd2);
    chk("fwd_b_young", fwd_b, 3'd1);
    issue(3'b001, 5'd9);
    chk("fwd_a_youngest", fwd_a, 3'd1);
    chk("fwd_b_shift", fwd_b, 3'd2);
    src_a = 5'd0;
    #1;
    chk("src0_no_haz", hazard_a, 1'b0);
    chk("src0_no_fwd", fwd_a, 3'd0);
    src_a = 5'd7;
    #1 chk("nomatch_no_haz", hazard_a, 1'b0);
    src_a = 5'd0; src_b = 5'd0;
    drain();

    // Stall holds a valid entry at stage 1 and ignores new input
    issue(3'b001, 5'd9);
    step();
    chk("pre_stall_valid", stage_valid, 3'b010);
    stall = 1'b1;
    in_valid = 1'b1; RegWrite = 1'b1; RegDest = 3'b001; RD = 5'd12;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stall_valid%0d", i), stage_valid, 3'b010);
      chk($sformatf("stall_dest%0d", i), stage_dest[9:5], 5'd9);
    end
    stall = 1'b0; in_valid = 1'b0;
    step();
    chk("post_stall_valid", stage_valid, 3'b100);
    chk("post_stall_wb", wb_dest, 5'd9);
    drain();

    // Flush beats stall and drops the current input
    issue(3'b001, 5'd9);
    issue(3'b001, 5'd12);
    chk("pre_flush_valid", stage_valid, 3'b011);
    flush = 1'b1; stall = 1'b1;
    in_valid = 1'b1; RegWrite = 1'b1; RegDest = 3'b001; RD = 5'd3;
    step();
    chk("flush_valid", stage_valid, 3'b000);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    step();
    chk("flush_input_dropped", stage_valid, 3'b000);

    // Asynchronous reset mid-stream
    RT = 5'd5;
    issue(3'b000, 5'd0);
    issue(3'b001, 5'd9);
    issue(3'b100, 5'd0);
    src_a = 5'd5;
    #1;
    chk("pre_rst_valid", stage_valid, 3'b111);
    chk("pre_rst_err", err_sel, 1'b1);
    chk("pre_rst_haz", hazard_a, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", stage_valid, 3'b000);
    chk("async_rst_dest", stage_dest, 15'd0);
    chk("async_rst_wb_dest", wb_dest, 5'd0);
    chk("async_rst_err", err_sel, 1'b0);
    chk("async_rst_haz", hazard_a, 1'b0);
    chk("async_rst_fwd", fwd_a, 3'd0);
    #3 reset = 1'b1;
    issue(3'b000, 5'd0);
    step();
    chk("post_rst_lat2", wb_valid, 1'b0);
    step();
    chk("post_rst_wb_valid", wb_valid, 1'b1);
    chk("post_rst_wb_dest", wb_dest, 5'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
